// File: rtl/wb_dma_copy_pkg.sv
// rtl/wb_dma_copy_pkg.sv - shared types and constants for the Wishbone block-copy engine
package wb_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_GAP,
    ST_WR,
    ST_WR_GAP,
    ST_DONE
  } dma_state_t;

  localparam logic [3:0]  WB_SEL_ALL = 4'hF;
  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/wb_dma_copy_if.sv
// rtl/wb_dma_copy_if.sv - classic single-beat Wishbone bus between controller and peripheral
interface wb_dma_copy_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack, err);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack, err);

endinterface

// File: rtl/wb_dma_copy.sv
// rtl/wb_dma_copy.sv - copies a block of words read-then-write over Wishbone, with timeout abort
module wb_dma_copy
  import wb_dma_pkg::*;
#(
  parameter int LEN_BITS       = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  wb_dma_copy_if.master       wb,
  input  logic                i_start,
  input  logic [31:0]         i_src_addr,
  input  logic [31:0]         i_dst_addr,
  input  logic [LEN_BITS-1:0] i_len_words,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  dma_state_t          state_q, state_d;
  logic [31:0]         src_q, src_d;
  logic [31:0]         dst_q, dst_d;
  logic [31:0]         data_q, data_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                err_q, err_d;
  logic                beat_active;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    len_d   = len_q;
    err_d   = err_q;
    tmo_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          src_d   = i_src_addr & ~(WORD_BYTES - 32'd1);
          dst_d   = i_dst_addr & ~(WORD_BYTES - 32'd1);
          len_d   = i_len_words;
          err_d   = 1'b0;
          state_d = (i_len_words == '0) ? ST_DONE : ST_RD;
        end
      end
      ST_RD, ST_WR: begin
        // err wins over a simultaneous ack; the beat is dropped without advancing
        if (wb.err) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (wb.ack) begin
          if (state_q == ST_RD) begin
            data_d  = wb.dat_r;
            state_d = ST_RD_GAP;
          end else begin
            src_d   = src_q + WORD_BYTES;
            dst_d   = dst_q + WORD_BYTES;
            len_d   = len_q - LEN_BITS'(1);
            state_d = ST_WR_GAP;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RD_GAP: state_d = ST_WR;
      ST_WR_GAP: state_d = (len_q == '0) ? ST_DONE : ST_RD;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign beat_active = (state_q == ST_RD) || (state_q == ST_WR);

  assign wb.cyc   = beat_active;
  assign wb.stb   = beat_active;
  assign wb.we    = (state_q == ST_WR);
  assign wb.sel   = beat_active ? WB_SEL_ALL : 4'h0;
  assign wb.adr   = (state_q == ST_WR) ? dst_q : src_q;
  assign wb.dat_w = data_q;

  assign o_busy = (state_q != ST_IDLE);
  assign o_done = (state_q == ST_DONE);
  assign o_err  = err_q;

endmodule
